tstate_seq: RTL and testbench

- Parametrised one-hot timing-state sequencer for the 6502 core; successor to the fixed T0..T7/RMW sequencer inside control.
- Owns the T-state register, the rdy stall policy, jam detection and interrupt sampling at instruction boundaries.
- Exposes per-instruction cycle count.
- The decode/datapath steering logic drives tlast/skip_t0/to_rmw back into it combinationally from the current tstate.

---
 rtl/tstate_seq.sv | 165 ++++++++++++++++
 tb/tb_tstate_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tstate_seq.sv
// ---------------------------------------------------------------------------
// tstate_seq -- one-hot timing-state sequencer for a 6502-style core.
//
// Owns the T-state register, the rdy stall policy, jam detection, NMI edge
// latching and interrupt sampling at instruction boundaries. It also counts
// the cycles completed in the current instruction. Decode logic looks at
// o_tstate and drives i_tlast / i_skip_t0 / i_to_rmw back combinationally.
//
// Parameters:
//   NT          number of main T states T0..T(NT-1), NT >= 3
//   NRMW        number of read-modify-write detour states, NRMW >= 1
//   WRITE_STALL 0: rdy ignored on write cycles, 1: rdy stalls every cycle
//   CNT_W       width of the cycle counter, CNT_W >= 2
//
// Ports:
//   i_clk         clock
//   i_rst         synchronous reset, active-high
//   i_rdy         bus ready; low stalls (subject to WRITE_STALL)
//   i_write_cycle current cycle is a bus write
//   i_tlast       current state is the last cycle of the instruction
//   i_skip_t0     with i_tlast, go straight to T1
//   i_to_rmw      enter the RMW detour next
//   i_nmi         non-maskable interrupt request, rising-edge sensitive
//   i_irq         maskable interrupt request, level
//   i_irq_mask    I flag
//   i_int_ack     clears the latched NMI
//   o_tstate      one-hot state: bit k = Tk, bit NT+j = RMW(j+1)
//   o_sync        current state is T1 (opcode fetch)
//   o_advance     state register updates this cycle
//   o_jam         sequencer jammed (o_tstate all zeros)
//   o_int_taken   current instruction is an interrupt sequence
//   o_nmi_pending NMI edge latched and not yet acknowledged
//   o_cyc_count   cycles completed in the current instruction (saturating)
// ---------------------------------------------------------------------------
module tstate_seq #(
  parameter int NT          = 8,
  parameter int NRMW        = 2,
  parameter int WRITE_STALL = 0,
  parameter int CNT_W       = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rdy,
  input  logic                 i_write_cycle,
  input  logic                 i_tlast,
  input  logic                 i_skip_t0,
  input  logic                 i_to_rmw,
  input  logic                 i_nmi,
  input  logic                 i_irq,
  input  logic                 i_irq_mask,
  input  logic                 i_int_ack,
  output logic [NT+NRMW-1:0]   o_tstate,
  output logic                 o_sync,
  output logic                 o_advance,
  output logic                 o_jam,
  output logic                 o_int_taken,
  output logic                 o_nmi_pending,
  output logic [CNT_W-1:0]     o_cyc_count
);

  localparam int NS = NT + NRMW;

  localparam logic [NS-1:0]    ST_ONE    = {{(NS-1){1'b0}}, 1'b1};
  localparam logic [NS-1:0]    ST_T0     = ST_ONE;
  localparam logic [NS-1:0]    ST_T1     = ST_ONE << 1;
  localparam logic [NS-1:0]    ST_RMW1   = ST_ONE << NT;
  localparam logic [NS-1:0]    ST_NONE   = {NS{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  // Write cycles bypass rdy only in the NMOS-compatible configuration.
  localparam logic             WR_BYPASS = (WRITE_STALL == 0) ? 1'b1 : 1'b0;

  logic [NS-1:0]    r_tstate;
  logic             r_int_taken;
  logic             r_nmi_pending;
  logic             r_nmi_prev;
  logic [CNT_W-1:0] r_cyc_count;

  logic [NS-1:0]    w_succ;
  logic [NS-1:0]    w_next;
  logic             w_jam;
  logic             w_advance;
  logic             w_nmi_edge;

  // An all-zero state vector is the jam condition; it can only be left by reset.
  assign w_jam      = (r_tstate == ST_NONE);
  assign w_advance  = ~w_jam & (i_rdy | (i_write_cycle & WR_BYPASS));
  assign w_nmi_edge = i_nmi & ~r_nmi_prev;

  // Natural successor: shift within the main chain and within the RMW chain.
  // T(NT-1) and the final RMW state have no successor, so they fall into jam.
  always_comb begin
    w_succ = ST_NONE;
    for (int k = 0; k < NT - 1; k++) begin
      w_succ[k+1] = r_tstate[k];
    end
    for (int j = NT; j < NS - 1; j++) begin
      w_succ[j+1] = r_tstate[j];
    end
  end

  // Next-state priority: end of instruction, then RMW entry, then successor.
  always_comb begin
    w_next = ST_NONE;
    if (i_tlast) begin
      if (i_skip_t0) begin
        w_next = ST_T1;
      end else begin
        w_next = ST_T0;
      end
    end else if (i_to_rmw) begin
      w_next = ST_RMW1;
    end else begin
      w_next = w_succ;
    end
  end

  // State, cycle counter, NMI latch and interrupt sampling registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tstate      <= ST_T1;
      r_int_taken   <= 1'b0;
      r_nmi_pending <= 1'b0;
      r_nmi_prev    <= 1'b0;
      r_cyc_count   <= CNT_ZERO;
    end else begin
      // NMI edge detection runs every cycle, independent of rdy or jam.
      r_nmi_prev <= i_nmi;
      if (w_nmi_edge) begin
        r_nmi_pending <= 1'b1;
      end else if (i_int_ack) begin
        r_nmi_pending <= 1'b0;
      end else begin
        r_nmi_pending <= r_nmi_pending;
      end

      if (w_advance) begin
        r_tstate <= w_next;
        if (i_tlast) begin
          // Instruction boundary: restart the count and sample interrupts.
          r_cyc_count <= CNT_ZERO;
          r_int_taken <= r_nmi_pending | (i_irq & ~i_irq_mask);
        end else if (r_cyc_count != CNT_MAX) begin
          r_cyc_count <= r_cyc_count + CNT_ONE;
        end else begin
          r_cyc_count <= r_cyc_count;
        end
      end else begin
        r_tstate    <= r_tstate;
        r_cyc_count <= r_cyc_count;
        r_int_taken <= r_int_taken;
      end
    end
  end

  assign o_tstate      = r_tstate;
  assign o_sync        = r_tstate[1];
  assign o_advance     = w_advance;
  assign o_jam         = w_jam;
  assign o_int_taken   = r_int_taken;
  assign o_nmi_pending = r_nmi_pending;
  assign o_cyc_count   = r_cyc_count;

endmodule

// File: tb/tb_tstate_seq.sv
// ---------------------------------------------------------------------------
// tb_tstate_seq -- self-checking bench for tstate_seq.
// Two instances share all inputs: A uses defaults (NT=8, NRMW=2,
// WRITE_STALL=0, CNT_W=4); B uses WRITE_STALL=1 and CNT_W=2. A behavioural
// model (state kind + index, integer counters) tracks each instance.
// ---------------------------------------------------------------------------
module tb_tstate_seq;

  typedef struct packed {
    logic rst, rdy, wc, tlast, skip, rmw, nmi, irq, mask, ack;
  } vec_t;

  typedef struct {
    bit jam;
    bit rmw;
    int idx;
    int cyc;
    bit taken;
    bit pend;
    bit prev;
  } mdl_t;

  typedef struct {
    vec_t v;
    int   ts_bit;
    int   cyc;
    bit   adv;
  } row_t;

  logic clk;
  logic rst, rdy, wc, tlast, skip, to_rmw, nmi, irq, mask, ack;

  logic [9:0] ts_a, ts_b;
  logic       sync_a, adv_a, jam_a, taken_a, pend_a;
  logic       sync_b, adv_b, jam_b, taken_b, pend_b;
  logic [3:0] cyc_a;
  logic [1:0] cyc_b;

  int n_pass  = 0;
  int n_total = 0;

  mdl_t ma, mb;
  vec_t cur;
  row_t tbl[20];

  tstate_seq #(.NT(8), .NRMW(2), .WRITE_STALL(0), .CNT_W(4)) u_a (
    .i_clk(clk), .i_rst(rst), .i_rdy(rdy), .i_write_cycle(wc), .i_tlast(tlast),
    .i_skip_t0(skip), .i_to_rmw(to_rmw), .i_nmi(nmi), .i_irq(irq),
    .i_irq_mask(mask), .i_int_ack(ack), .o_tstate(ts_a), .o_sync(sync_a),
    .o_advance(adv_a), .o_jam(jam_a), .o_int_taken(taken_a),
    .o_nmi_pending(pend_a), .o_cyc_count(cyc_a)
  );

  tstate_seq #(.NT(8), .NRMW(2), .WRITE_STALL(1), .CNT_W(2)) u_b (
    .i_clk(clk), .i_rst(rst), .i_rdy(rdy), .i_write_cycle(wc), .i_tlast(tlast),
    .i_skip_t0(skip), .i_to_rmw(to_rmw), .i_nmi(nmi), .i_irq(irq),
    .i_irq_mask(mask), .i_int_ack(ack), .o_tstate(ts_b), .o_sync(sync_b),
    .o_advance(adv_b), .o_jam(jam_b), .o_int_taken(taken_b),
    .o_nmi_pending(pend_b), .o_cyc_count(cyc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic mdl_t reset_mdl();
    mdl_t m;
    m.jam = 0; m.rmw = 0; m.idx = 1; m.cyc = 0;
    m.taken = 0; m.pend = 0; m.prev = 0;
    return m;
  endfunction

  function automatic bit exp_adv(mdl_t m, vec_t v, int ws);
    return !m.jam && (v.rdy || (v.wc && ws == 0));
  endfunction

  function automatic logic [31:0] exp_ts(mdl_t m);
    int pos;
    if (m.jam) return 32'd0;
    pos = m.rmw ? (8 + m.idx - 1) : m.idx;
    return 32'd1 << pos;
  endfunction

  // One clock of the reference behaviour: main states T0..T7, RMW1..RMW2.
  function automatic mdl_t mstep(mdl_t m, vec_t v, int ws, int cmax);
    mdl_t n;
    bit   adv;
    if (v.rst) return reset_mdl();
    n   = m;
    adv = exp_adv(m, v, ws);
    if (v.nmi && !m.prev) n.pend = 1;
    else if (v.ack)       n.pend = 0;
    n.prev = v.nmi;
    if (adv) begin
      if (v.tlast) begin
        n.taken = m.pend || (v.irq && !v.mask);
        n.rmw   = 0;
        n.idx   = v.skip ? 1 : 0;
        n.cyc   = 0;
      end else begin
        n.cyc = (m.cyc + 1 > cmax) ? cmax : m.cyc + 1;
        if (v.rmw) begin
          n.rmw = 1; n.idx = 1;
        end else if (m.rmw) begin
          if (m.idx < 2) n.idx = m.idx + 1; else n.jam = 1;
        end else begin
          if (m.idx < 7) n.idx = m.idx + 1; else n.jam = 1;
        end
      end
    end
    return n;
  endfunction

  function automatic vec_t mkv(bit r, bit rd, bit w, bit tl, bit sk, bit rm);
    vec_t v;
    v = '0;
    v.rst = r; v.rdy = rd; v.wc = w; v.tlast = tl; v.skip = sk; v.rmw = rm;
    return v;
  endfunction

  function automatic row_t mkrow(bit rd, bit w, bit tl, bit sk, bit rm,
                                 int tsb, int c, bit a);
    row_t r;
    r.v = mkv(1'b0, rd, w, tl, sk, rm);
    r.ts_bit = tsb; r.cyc = c; r.adv = a;
    return r;
  endfunction

  // Drive inputs after the falling edge and compare both DUTs to the model.
  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.rst; rdy = v.rdy; wc = v.wc; tlast = v.tlast; skip = v.skip;
    to_rmw = v.rmw; nmi = v.nmi; irq = v.irq; mask = v.mask; ack = v.ack;
    #1;
    chk("A.tstate",  32'(ts_a),    exp_ts(ma));
    chk("A.sync",    32'(sync_a),  32'(!ma.jam && !ma.rmw && ma.idx == 1));
    chk("A.advance", 32'(adv_a),   32'(exp_adv(ma, v, 0)));
    chk("A.jam",     32'(jam_a),   32'(ma.jam));
    chk("A.taken",   32'(taken_a), 32'(ma.taken));
    chk("A.nmi_pend",32'(pend_a),  32'(ma.pend));
    chk("A.cyc",     32'(cyc_a),   32'(ma.cyc));
    chk("B.tstate",  32'(ts_b),    exp_ts(mb));
    chk("B.sync",    32'(sync_b),  32'(!mb.jam && !mb.rmw && mb.idx == 1));
    chk("B.advance", 32'(adv_b),   32'(exp_adv(mb, v, 1)));
    chk("B.jam",     32'(jam_b),   32'(mb.jam));
    chk("B.taken",   32'(taken_b), 32'(mb.taken));
    chk("B.nmi_pend",32'(pend_b),  32'(mb.pend));
    chk("B.cyc",     32'(cyc_b),   32'(mb.cyc));
  endtask

  task automatic tick(input vec_t v);
    @(posedge clk);
    ma = mstep(ma, v, 0, 15);
    mb = mstep(mb, v, 1, 3);
  endtask

  task automatic cycle(input vec_t v);
    apply(v);
    tick(v);
  endtask

  initial begin
    ma = reset_mdl();
    mb = reset_mdl();
    cur = mkv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; rdy = 1'b1; wc = 1'b0; tlast = 1'b0; skip = 1'b0;
    to_rmw = 1'b0; nmi = 1'b0; irq = 1'b0; mask = 1'b0; ack = 1'b0;
    @(posedge clk);
    tick(cur);

    // Directed walk: expected one-hot bit, count and advance for instance A.
    //                 rdy wc tl sk rm  bit cyc adv
    tbl[0]  = mkrow(1, 0, 0, 0, 0,  1, 0, 1);
    tbl[1]  = mkrow(1, 0, 0, 0, 0,  2, 1, 1);
    tbl[2]  = mkrow(1, 0, 1, 0, 0,  3, 2, 1);
    tbl[3]  = mkrow(1, 0, 0, 0, 0,  0, 0, 1);
    tbl[4]  = mkrow(1, 0, 0, 0, 0,  1, 1, 1);
    tbl[5]  = mkrow(1, 0, 0, 0, 0,  2, 2, 1);
    tbl[6]  = mkrow(1, 0, 0, 0, 1,  3, 3, 1);
    tbl[7]  = mkrow(1, 0, 0, 0, 0,  8, 4, 1);
    tbl[8]  = mkrow(1, 0, 1, 0, 0,  9, 5, 1);
    tbl[9]  = mkrow(1, 0, 0, 0, 0,  0, 0, 1);
    tbl[10] = mkrow(1, 0, 0, 0, 0,  1, 1, 1);
    tbl[11] = mkrow(1, 0, 1, 0, 1,  2, 2, 1);
    tbl[12] = mkrow(1, 0, 0, 0, 0,  0, 0, 1);
    tbl[13] = mkrow(1, 0, 0, 0, 0,  1, 1, 1);
    tbl[14] = mkrow(0, 0, 0, 0, 0,  2, 2, 0);
    tbl[15] = mkrow(0, 0, 0, 0, 0,  2, 2, 0);
    tbl[16] = mkrow(0, 0, 0, 0, 0,  2, 2, 0);
    tbl[17] = mkrow(0, 1, 0, 0, 0,  2, 2, 1);
    tbl[18] = mkrow(1, 0, 1, 1, 0,  3, 3, 1);
    tbl[19] = mkrow(1, 0, 0, 0, 0,  1, 0, 1);

    chk("reset.tstate", 32'(ts_a), 32'h002);
    chk("reset.cyc",    32'(cyc_a), 32'd0);
    for (int i = 0; i < 20; i++) begin
      apply(tbl[i].v);
      chk($sformatf("tbl%0d.tstate", i), 32'(ts_a), 32'd1 << tbl[i].ts_bit);
      chk($sformatf("tbl%0d.cyc", i),    32'(cyc_a), 32'(tbl[i].cyc));
      chk($sformatf("tbl%0d.adv", i),    32'(adv_a), 32'(tbl[i].adv));
      if (i == 8) chk("B.cyc_sat_rmw", 32'(cyc_b), 32'd3);
      if (i == 17) chk("B.write_stall", 32'(adv_b), 32'd0);
      tick(tbl[i].v);
    end

    // Jam: run off the end of the main chain, then random inputs without rst.
    cycle(mkv(1, 1, 0, 0, 0, 0));
    for (int i = 0; i < 7; i++) cycle(mkv(0, 1, 0, 0, 0, 0));
    #1;
    chk("jam.A.flag",   32'(jam_a), 32'd1);
    chk("jam.A.tstate", 32'(ts_a),  32'd0);
    chk("jam.A.cyc",    32'(cyc_a), 32'd7);
    chk("jam.B.cyc",    32'(cyc_b), 32'd3);
    for (int i = 0; i < 20; i++) begin
      cur = vec_t'($urandom_range(0, 1023));
      cur.rst = 1'b0;
      cycle(cur);
    end
    #1;
    chk("jam.hold", 32'(jam_a), 32'd1);
    cycle(mkv(1, 0, 0, 0, 0, 0));
    #1;
    chk("jam.rst.tstate", 32'(ts_a), 32'h002);
    chk("jam.rst.jam",    32'(jam_a), 32'd0);

    // Interrupts: NMI edge, sampling at tlast, ack, no re-trigger, masking.
    cur = mkv(0, 1, 0, 0, 0, 0); cur.nmi = 1; cycle(cur);
    #1; chk("nmi.pending", 32'(pend_a), 32'd1);
    cycle(cur);
    cur.tlast = 1; cycle(cur);
    #1; chk("nmi.taken", 32'(taken_a), 32'd1);
    cur.tlast = 0; cur.ack = 1; cycle(cur);
    #1; chk("nmi.ack", 32'(pend_a), 32'd0);
    cur.ack = 0; cycle(cur);
    #1; chk("nmi.no_retrig", 32'(pend_a), 32'd0);
    cur.irq = 1; cur.mask = 1; cur.tlast = 1; cycle(cur);
    #1; chk("irq.masked", 32'(taken_a), 32'd0);
    cur.mask = 0; cycle(cur);
    #1; chk("irq.taken", 32'(taken_a), 32'd1);
    cur.irq = 0; cur.tlast = 0; cur.nmi = 0; cycle(cur);
    cur.nmi = 1; cur.ack = 1; cycle(cur);
    #1; chk("nmi.edge_vs_ack", 32'(pend_a), 32'd1);
    cur.ack = 0; cur.rdy = 0; cur.tlast = 1; cur.irq = 0; cycle(cur);
    #1; chk("stall.no_sample", 32'(taken_a), 32'd1);

    // Randomised run against the model, with occasional resets.
    for (int i = 0; i < 800; i++) begin
      cur = '0;
      cur.rst   = ($urandom_range(0, 29) == 0);
      cur.rdy   = ($urandom_range(0, 3) != 0);
      cur.wc    = $urandom_range(0, 1);
      cur.tlast = ($urandom_range(0, 4) == 0);
      cur.skip  = $urandom_range(0, 1);
      cur.rmw   = ($urandom_range(0, 7) == 0);
      cur.nmi   = ($urandom_range(0, 3) == 0);
      cur.irq   = $urandom_range(0, 1);
      cur.mask  = $urandom_range(0, 1);
      cur.ack   = ($urandom_range(0, 5) == 0);
      cycle(cur);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
